// File: rtl/alu_bit_serial_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_bit_serial_seq
// Purpose  : Bit-serial ALU sequencer, one operand bit per clock, LSB first.
//            Optional signed-overflow output enabled by ALU_SEQ_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_bit_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ainv,
  input  logic             binv,
  input  logic             cinv,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_LAST   = CW'(WIDTH - 1);
  localparam logic [2:0]    c_OP_AND = 3'b000;
  localparam logic [2:0]    c_OP_OR  = 3'b001;
  localparam logic [2:0]    c_OP_XOR = 3'b010;
  localparam logic [2:0]    c_OP_NOR = 3'b011;
  localparam logic [2:0]    c_OP_ADD = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sr;
  logic             r_ainv;
  logic             r_binv;
  logic             r_carry;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_cout;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  logic             w_ai;
  logic             w_bi;
  logic             w_s;
  logic             w_carry_nxt;
  logic             w_is_add;
  logic [WIDTH-1:0] w_sr_nxt;

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_last      = (r_state == S_RUN) && (r_cnt == c_LAST);
  // Operand copies shift right each bit, so the current bit is always at [0].
  assign w_ai        = r_a[0] ^ r_ainv;
  assign w_bi        = r_b[0] ^ r_binv;
  assign w_is_add    = (r_op == c_OP_ADD);
  assign w_carry_nxt = (w_ai & w_bi) | (r_carry & (w_ai ^ w_bi));
  assign w_sr_nxt    = {w_s, r_sr[WIDTH-1:1]};

  always_comb begin
    w_s = 1'b0;
    case (r_op)
      c_OP_AND: w_s = w_ai & w_bi;
      c_OP_OR:  w_s = w_ai | w_bi;
      c_OP_XOR: w_s = w_ai ^ w_bi;
      c_OP_NOR: w_s = ~(w_ai | w_bi);
      c_OP_ADD: w_s = w_ai ^ w_bi ^ r_carry;
      default:  w_s = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == c_LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sr    <= '0;
      r_ainv  <= 1'b0;
      r_binv  <= 1'b0;
      r_carry <= 1'b0;
      r_op    <= 3'b000;
      r_cnt   <= '0;
      r_cout  <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_ainv  <= ainv;
      r_binv  <= binv;
      r_op    <= op;
      r_carry <= cinv;
      r_cnt   <= '0;
      r_sr    <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_carry_nxt;
      r_cnt   <= r_cnt + CW'(1);
      r_sr    <= w_sr_nxt;
      if (w_last) begin
        r_cout <= w_is_add & w_carry_nxt;
        r_zero <= (w_sr_nxt == '0);
      end
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic r_ovf;

  // At the last bit, r_carry is the carry into the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= w_is_add & (r_carry ^ w_carry_nxt);
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign result = r_sr;
  assign cout   = r_cout;
  assign zero   = r_zero;

endmodule
`default_nettype wire
